// File: rtl/io_bridge_pkg.sv
// Shared address map and read-source encoding for the CPU IO bridge.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package io_bridge_pkg;

    // IO window is selected by address bits 17:16 == 2'b11.
    localparam logic [17:0] IO_BASE     = 18'h30000;
    // Data port: TX write / RX read.
    localparam logic [15:0] IO_OFF_DATA = 16'h0000;
    // Cycle counter: write stops the program, reads return snapshot bytes.
    localparam logic [15:0] IO_OFF_CNT  = 16'h0004;

    // Registered read-data source for the cycle after an address.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_RX   = 2'd2,
        SEL_CNT  = 2'd3
    } src_sel_e;

endpackage

// File: rtl/io_fifo.sv
// Generic synchronous FIFO with occupancy count; head is shown combinationally.
// Latency: one cycle from push to head visibility.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
module io_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Qualify push/pop and advance pointers and occupancy.
    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != FULL_CNT) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is not reset: clearing the pointers discards the contents.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and count state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/io_bridge.sv
// CPU bus bridge: RAM pass-through, UART TX/RX byte ports, cycle counter and program-stop flag.
// Latency: read data one cycle after the address; TX byte visible one cycle after the write.
// Backpressure: cpu_rdy drops while the TX FIFO is full; optional RX FIFO (IO_RX_FIFO_EN) backpressures rx_ready.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    input  logic [7:0]  ram_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog_stop
);

    logic is_io, hit_data, hit_cnt, hit_cnt_blk;
    logic wr_acc, rd_acc;

    // Address decode and CPU access qualification (a paused CPU has no side effects).
    always_comb begin
        is_io       = (cpu_a[17:16] == IO_BASE[17:16]);
        hit_data    = is_io && (cpu_a[15:0] == IO_OFF_DATA);
        hit_cnt     = is_io && (cpu_a[15:0] == IO_OFF_CNT);
        hit_cnt_blk = is_io && (cpu_a[15:2] == IO_OFF_CNT[15:2]);
        wr_acc      = cpu_wr & cpu_rdy;
        rd_acc      = ~cpu_wr & cpu_rdy;
    end

    // RAM port: gated write so IO accesses and reset never write memory.
    assign ram_a    = cpu_a[16:0];
    assign ram_dout = cpu_dout;
    assign ram_we   = wr_acc & ~is_io & rst_in;

    // ---------------- TX path ----------------
    logic                        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]                  tx_din;
    logic [$clog2(TX_DEPTH):0]   tx_count;

    // Zero bytes are dropped on the data port; the stop write injects a zero terminator.
    always_comb begin
        tx_push = wr_acc & ((hit_data & (cpu_dout != 8'h00)) | hit_cnt);
        tx_din  = hit_cnt ? 8'h00 : cpu_dout;
        tx_pop  = tx_valid & tx_ready;
    end

    io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (tx_push),
        .din    (tx_din),
        .pop    (tx_pop),
        .dout   (tx_data),
        .full   (tx_full),
        .empty  (tx_empty),
        .count  (tx_count)
    );

    assign tx_valid = ~tx_empty;
    assign cpu_rdy  = ~tx_full;

    // ---------------- counter, snapshot, read select ----------------
    src_sel_e    sel_q, sel_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic        stop_q, stop_d;

    // Next-state for free-running counter, snapshot, sticky stop and read source.
    always_comb begin
        sel_d  = SEL_ZERO;
        byte_d = cpu_a[1:0];
        cnt_d  = cnt_q + 32'd1;
        snap_d = snap_q;
        stop_d = stop_q;
        if (!cpu_wr) begin
            if (!is_io) begin
                sel_d = SEL_RAM;
            end else if (hit_data) begin
                sel_d = SEL_RX;
            end else if (hit_cnt_blk) begin
                sel_d = SEL_CNT;
            end
        end
        if (rd_acc && hit_cnt) begin
            snap_d = cnt_q;
        end
        if (wr_acc && hit_cnt) begin
            stop_d = 1'b1;
        end
    end

    // Bridge state registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sel_q  <= SEL_ZERO;
            byte_q <= 2'd0;
            cnt_q  <= 32'd0;
            snap_q <= 32'd0;
            stop_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            byte_q <= byte_d;
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
            stop_q <= stop_d;
        end
    end

    assign prog_stop = stop_q;

    // ---------------- RX path ----------------
    logic unused_bits;

`ifdef IO_RX_FIFO_EN
    logic                        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]                  rx_head;
    logic [7:0]                  rx_byte_q, rx_byte_d;
    logic [$clog2(RX_DEPTH):0]   rx_count;

    // A data-port read pops one byte, or latches zero when nothing is buffered.
    always_comb begin
        rx_push   = rx_valid & rx_ready;
        rx_pop    = rd_acc & hit_data;
        rx_byte_d = rx_byte_q;
        if (rd_acc && hit_data) begin
            rx_byte_d = rx_empty ? 8'h00 : rx_head;
        end
    end

    io_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (rx_push),
        .din    (rx_data),
        .pop    (rx_pop),
        .dout   (rx_head),
        .full   (rx_full),
        .empty  (rx_empty),
        .count  (rx_count)
    );

    // Holds the byte returned to the CPU in the cycle after the read.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_byte_q <= 8'h00;
        end else begin
            rx_byte_q <= rx_byte_d;
        end
    end

    assign rx_ready    = ~rx_full & rst_in;
    assign unused_bits = ^{cpu_a[31:18], tx_count, rx_count};
`else
    assign rx_ready    = 1'b0;
    assign unused_bits = ^{cpu_a[31:18], tx_count, rx_data, rx_valid, 1'(RX_DEPTH)};
`endif

    // Read-data mux driven by the source registered in the previous cycle.
    always_comb begin
        cpu_din = 8'h00;
        case (sel_q)
            SEL_RAM: cpu_din = ram_din;
            SEL_CNT: begin
                case (byte_q)
                    2'd0:    cpu_din = snap_q[7:0];
                    2'd1:    cpu_din = snap_q[15:8];
                    2'd2:    cpu_din = snap_q[23:16];
                    default: cpu_din = snap_q[31:24];
                endcase
            end
`ifdef IO_RX_FIFO_EN
            SEL_RX:  cpu_din = rx_byte_q;
`else
            SEL_RX:  cpu_din = 8'h00;
`endif
            default: cpu_din = 8'h00;
        endcase
    end

endmodule
